// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver pair.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so idle-high lines do not glitch out of reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, validates the start bit at half a bit,
// samples data at bit centres and offers each byte on a valid/ack handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ack,
    output logic                      framing_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    logic                      r_rx_s_d;
    uart_state_t               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .i_reset (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s_d    <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_rx_s_d    <= w_rx_s;
            framing_err <= 1'b0;
            overrun     <= 1'b0;

            // A byte landing this cycle overrides the clear below.
            if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_rx_s_d && !w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        if (w_rx_s) begin
                            data_out   <= r_shift;
                            data_valid <= 1'b1;
                            overrun    <= data_valid && !data_ack;
                        end else begin
                            framing_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised frame bench for uart_rx; observations are recorded
// per cycle relative to the first low sample of each run and checked after.
module tb_uart_rx;

    localparam int MAXC = 400;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic       line_pat [0:MAXC-1];
    logic [7:0] obs_dv   [0:MAXC-1];
    logic [7:0] obs_fe   [0:MAXC-1];
    logic [7:0] obs_ov   [0:MAXC-1];
    logic [7:0] obs_busy [0:MAXC-1];
    logic [7:0] obs_data [0:MAXC-1];

    uart_rx #(
        .CLKS_PER_BIT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ack    (data_ack),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 16 clocks per bit: start, d0..d7 LSB first, stop.
    task automatic put_frame(input int off, input logic [7:0] b, input logic stop);
        for (int i = 0; i < 160; i++) begin
            if (i < 16)       line_pat[off+i] = 1'b0;
            else if (i < 144) line_pat[off+i] = b[3'((i - 16) / 16)];
            else              line_pat[off+i] = stop;
        end
    endtask

    task automatic put_level(input int off, input int n, input logic v);
        for (int i = 0; i < n; i++) line_pat[off+i] = v;
    endtask

    task automatic run(input int ncyc, input int ack_at, input int rst_at);
        for (int c = 0; c < ncyc; c++) begin
            rx       = line_pat[c];
            data_ack = (c == ack_at);
            reset    = (c == rst_at);
            @(posedge clk);
            #1;
            obs_dv[c]   = 8'(data_valid);
            obs_fe[c]   = 8'(framing_err);
            obs_ov[c]   = 8'(overrun);
            obs_busy[c] = 8'(busy);
            obs_data[c] = data_out;
        end
        data_ack = 1'b0;
        reset    = 1'b0;
        rx       = 1'b1;
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
    endtask

    function automatic int count(input int which, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) begin
            case (which)
                0:       n += int'(obs_fe[c]);
                1:       n += int'(obs_ov[c]);
                2:       n += int'(obs_dv[c]);
                default: n += int'(obs_busy[c]);
            endcase
        end
        return n;
    endfunction

    initial begin
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ov;
        logic       exp_fe;
        logic [7:0] b;
        logic       stop;
        int         ack_at;

        reset    = 1'b1;
        rx       = 1'b1;
        data_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk8("rst_data_out", data_out, 8'h00);
        chk8("rst_valid", 8'(data_valid), 8'h00);
        chk8("rst_ferr", 8'(framing_err), 8'h00);
        chk8("rst_overrun", 8'(overrun), 8'h00);
        chk8("rst_busy", 8'(busy), 8'h00);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Clean frame 0xA5, no ack.
        put_frame(0, 8'hA5, 1'b1);
        put_level(160, 10, 1'b1);
        run(170, -1, -1);
        $display("frame A5 clean: data_out=%h valid=%0d", obs_data[169], obs_dv[169]);
        chk8("a5_busy_t1", obs_busy[1], 8'h00);
        chk8("a5_busy_t2", obs_busy[2], 8'h01);
        chk8("a5_busy_t153", obs_busy[153], 8'h01);
        chk8("a5_busy_t154", obs_busy[154], 8'h00);
        chk8("a5_valid_t153", obs_dv[153], 8'h00);
        chk8("a5_valid_t154", obs_dv[154], 8'h01);
        chk8("a5_data", obs_data[169], 8'hA5);
        chki("a5_ferr_count", count(0, 0, 169), 0);
        ack_pulse();
        chk8("a5_ack_clears", 8'(data_valid), 8'h00);

        // Start glitch: low for 6 cycles only.
        put_level(0, 6, 1'b0);
        put_level(6, 34, 1'b1);
        run(40, -1, -1);
        $display("glitch: busy t9=%0d t10=%0d", obs_busy[9], obs_busy[10]);
        chk8("glitch_busy_t2", obs_busy[2], 8'h01);
        chk8("glitch_busy_t9", obs_busy[9], 8'h01);
        chk8("glitch_busy_t10", obs_busy[10], 8'h00);
        chki("glitch_valid_count", count(2, 0, 39), 0);
        chki("glitch_ferr_count", count(0, 0, 39), 0);

        // Framing error followed by a held-low break.
        put_frame(0, 8'h3C, 1'b0);
        put_level(160, 100, 1'b0);
        run(260, -1, -1);
        $display("frame 3C bad stop: ferr pulses=%0d", count(0, 0, 259));
        chk8("ferr_t154", obs_fe[154], 8'h01);
        chki("ferr_count", count(0, 0, 259), 1);
        chki("ferr_valid_count", count(2, 0, 259), 0);
        chki("break_busy_count", count(3, 155, 259), 0);
        chk8("ferr_data_kept", obs_data[259], 8'hA5);

        put_level(0, 20, 1'b1);
        put_frame(20, 8'h81, 1'b1);
        put_level(180, 10, 1'b1);
        run(190, -1, -1);
        $display("frame 81 after break: data_out=%h valid=%0d", obs_data[189], obs_dv[189]);
        chk8("after_break_valid", obs_dv[189], 8'h01);
        chk8("after_break_data", obs_data[189], 8'h81);
        ack_pulse();

        // Back-to-back, no ack: overrun on the second byte.
        put_frame(0, 8'h11, 1'b1);
        put_frame(160, 8'h22, 1'b1);
        put_level(320, 10, 1'b1);
        run(330, -1, -1);
        $display("frames 11,22 no ack: overruns=%0d data_out=%h", count(1, 0, 329), obs_data[329]);
        chk8("b2b_ov_first", obs_ov[154], 8'h00);
        chk8("b2b_valid_first", obs_dv[154], 8'h01);
        chk8("b2b_ov_second", obs_ov[314], 8'h01);
        chki("b2b_ov_count", count(1, 0, 329), 1);
        chk8("b2b_data", obs_data[329], 8'h22);
        chk8("b2b_valid", obs_dv[329], 8'h01);
        ack_pulse();

        // Ack in the very cycle the second byte lands.
        run(330, 314, -1);
        $display("frames 11,22 ack at land: overruns=%0d data_out=%h", count(1, 0, 329), obs_data[329]);
        chki("samecyc_ov_count", count(1, 0, 329), 0);
        chk8("samecyc_valid_t314", obs_dv[314], 8'h01);
        chk8("samecyc_data", obs_data[314], 8'h22);
        chk8("samecyc_valid_end", obs_dv[329], 8'h01);

        // Reset during data bit 3, then a fresh frame.
        put_frame(0, 8'h00, 1'b1);
        put_level(70, 130, 1'b1);
        put_frame(200, 8'h5A, 1'b1);
        put_level(360, 10, 1'b1);
        run(370, -1, 70);
        $display("reset mid-frame then 5A: data_out=%h valid=%0d", obs_data[369], obs_dv[369]);
        chk8("rst_mid_valid_before", obs_dv[69], 8'h01);
        chk8("rst_mid_busy_before", obs_busy[69], 8'h01);
        chk8("rst_mid_valid", obs_dv[70], 8'h00);
        chk8("rst_mid_busy", obs_busy[70], 8'h00);
        chk8("rst_mid_data", obs_data[70], 8'h00);
        chki("rst_mid_flags", count(0, 70, 369) + count(1, 70, 369), 0);
        chki("rst_mid_no_valid", count(2, 70, 353), 0);
        chk8("rst_mid_5a_valid", obs_dv[354], 8'h01);
        chk8("rst_mid_5a_data", obs_data[369], 8'h5A);

        // Random frames against a handshake-level reference model.
        exp_valid = 1'b1;
        exp_data  = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       ack_at = -1;
                1:       ack_at = 154;
                default: ack_at = 80;
            endcase
            put_frame(0, b, stop);
            put_level(160, 16, 1'b1);
            run(176, ack_at, -1);

            if (ack_at == 80) exp_valid = 1'b0;
            exp_ov = 1'b0;
            exp_fe = 1'b0;
            if (stop) begin
                exp_ov    = exp_valid && (ack_at != 154);
                exp_valid = 1'b1;
                exp_data  = b;
            end else begin
                exp_fe = 1'b1;
                if (ack_at == 154) exp_valid = 1'b0;
            end
            $display("rand frame %0d byte=%h stop=%0d ack_at=%0d data_out=%h valid=%0d",
                     k, b, stop, ack_at, obs_data[175], obs_dv[175]);
            chk8("rand_ferr", obs_fe[154], 8'(exp_fe));
            chk8("rand_overrun", obs_ov[154], 8'(exp_ov));
            chki("rand_ov_count", count(1, 0, 175), int'(exp_ov));
            chk8("rand_valid", obs_dv[175], 8'(exp_valid));
            chk8("rand_data", obs_data[175], exp_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
